sprite_mover: RTL
=================

SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- SPR_W, 32, sprite width.
- SPR_H, 32, sprite height.
- STEP, 4, pixels moved per movement event (1..SPR_W).
- DEB_CYCLES, 250000, consecutive stable clocks required to accept a button change (>=2).
- REPEAT_DELAY, 15, frame ticks from first move to first auto-repeat move (>=1).
- REPEAT_RATE, 4, frame ticks between auto-repeat moves (>=1).
- COLOR, 12'h0F0, sprite RGB444 color.
REQ-002 Ports (name direction width meaning), one per line:
- clk in 1, pixel clock; one clock domain only.
- rst in 1, reset; asynchronous, active-high.
- left, right, up, down in 1 each, raw asynchronous button levels, active-high.
- frame_tick in 1, one-clock pulse once per frame.
- x, y in 10 each, current pixel coordinate.
- video_on in 1, current pixel is visible.
- pixel_color out 12, registered RGB444 output.
- sprite_x, sprite_y out 10 each, sprite top-left position.
- sprite_hit out 1, registered; pixel lies inside the sprite.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer and then a debounce counter.
REQ-004 The debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive clocks; any shorter glitch SHALL reset the counter with no change.
REQ-005 The horizontal direction SHALL be +1 when right=1 and left=0, -1 when left=1 and right=0, and 0 otherwise; debounced levels are used, so both pressed gives 0. The vertical direction is derived the same way from down and up.
REQ-006 Each axis SHALL have an independent FSM with states IDLE, DELAY and REPEAT.
REQ-007 IDLE with direction !=0: latch the direction, set the pending flag, go to DELAY.
REQ-008 The pending flag SHALL be consumed at the next frame_tick and apply exactly one move in the latched direction, even if the button was released before the tick (taps are never lost).
REQ-009 DELAY: the counter loads REPEAT_DELAY on the first move and decrements once per frame_tick. At zero it moves and goes to REPEAT with the counter loaded to REPEAT_RATE.
REQ-010 REPEAT: move once every REPEAT_RATE frame ticks while the direction is held.
REQ-011 Held-button timing: moves occur at tick 1, at tick 1+REPEAT_DELAY, then every REPEAT_RATE ticks.
REQ-012 Direction becomes 0 in DELAY or REPEAT: go to IDLE in the next clock; an unconsumed pending move still applies at the next tick.
REQ-013 Direction reverses while held: treated as a new press (IDLE semantics, pending move in the new direction).
REQ-014 Position SHALL change only on clocks where frame_tick=1, so no mid-frame tearing; both axes may move on the same tick.
REQ-015 Movement SHALL saturate and never wrap:
- x_new = max(0, x-STEP) or min(SCREEN_W-SPR_W, x+STEP).
- y is clamped the same way to [0, SCREEN_H-SPR_H].
- Arithmetic is computed 11 bits wide so underflow is never produced.
REQ-016 Hit test: sprite_hit SHALL be registered as (sprite_x <= x < sprite_x+SPR_W) and (sprite_y <= y < sprite_y+SPR_H) and video_on, using 11-bit sums.
REQ-017 pixel_color SHALL be registered as COLOR when the hit condition is true, else 12'h000; latency is exactly 1 clock from x/y/video_on.
REQ-018 video_on=0 SHALL force pixel_color=12'h000 and sprite_hit=0 on the next clock.

Reset
REQ-019 rst=1 SHALL immediately and asynchronously set the outputs and internal state as follows:
- sprite_x=(SCREEN_W-SPR_W)/2, sprite_y=(SCREEN_H-SPR_H)/2.
- pixel_color=0, sprite_hit=0.
- Synchronizers, debounced levels and debounce counters = 0.
- FSMs in IDLE, pending flags clear.
REQ-020 Reset asserted mid-hold or mid-debounce SHALL discard all progress; after release, a still-held button SHALL require a full DEB_CYCLES before it is accepted.

Verification
REQ-021 The bench SHALL cover these scenarios, using DEB_CYCLES=4, STEP=4, REPEAT_DELAY=3, REPEAT_RATE=2 unless stated:
- Reset: rst pulse -> sprite_x=304, sprite_y=224, pixel_color=0, sprite_hit=0.
- Debounce: right high 3 clocks then low, frame_tick -> sprite_x stays 304. Right high 10 clocks released before tick, then tick -> sprite_x=308 (tap kept).
- Auto-repeat: hold left over 8 frame ticks -> sprite_x 300 at tick 1, 296 at tick 4, 292 at tick 6, 288 at tick 8, unchanged at the other ticks.
- Saturation, with STEP=5: start at sprite_x=3 holding left -> sprite_x=0 and stays 0. At sprite_x=606 holding right -> 608 and stays. Up held from sprite_y=2 -> sprite_y=0.
- Conflict and reset: left+right and up+down held over 5 ticks -> no position change. rst during REPEAT -> position returns to 304/224 immediately.
- Pixel: sprite at (304,224), video_on=1, x=304,y=224 -> next clock pixel_color=0F0, sprite_hit=1. x=336 -> 000. x=335,y=255 -> 0F0. video_on=0 -> 000.

Source files
------------

// File: rtl/sprite_mover.sv
// sprite_mover: moves a sprite with debounced buttons (tap + auto-repeat) and overlays it on the pixel stream
//   clk, rst                   : pixel clock, async active-high reset
//   left/right/up/down         : raw asynchronous button levels
//   frame_tick                 : one-clock pulse per frame; the only time the position changes
//   x, y, video_on             : current pixel coordinate and visibility
//   pixel_color, sprite_hit    : registered overlay outputs, 1-clock latency
//   sprite_x, sprite_y         : sprite top-left position
module sprite_mover #(
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter int          STEP         = 4,
  parameter int          DEB_CYCLES   = 250000,
  parameter int          REPEAT_DELAY = 15,
  parameter int          REPEAT_RATE  = 4,
  parameter logic [11:0] COLOR        = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  output logic [11:0] pixel_color,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic        sprite_hit
);
  localparam logic [10:0] MAX_X = 11'(SCREEN_W - SPR_W);
  localparam logic [10:0] MAX_Y = 11'(SCREEN_H - SPR_H);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [3:0] btn, s1_q, s2_q, deb_q, deb_d;
  logic [DW-1:0] dcnt_q [4];
  logic [DW-1:0] dcnt_d [4];
  // Direction encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = none. Axis 0 = x, axis 1 = y.
  logic [1:0] dir_n [2];
  logic [1:0] dir_q [2];
  logic [1:0] dir_d [2];
  state_t st_q [2];
  state_t st_d [2];
  logic pend_q [2];
  logic pend_d [2];
  logic [RW-1:0] cnt_q [2];
  logic [RW-1:0] cnt_d [2];
  logic mv [2];
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic hit_d, hit_q;
  logic [11:0] pc_q;
  assign btn = {down, up, right, left};
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      dcnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
        if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
          dcnt_d[i] = '0;
        end
      end
    end
  end
  assign dir_n[0] = (deb_q[1] & ~deb_q[0]) ? 2'b01 : (deb_q[0] & ~deb_q[1]) ? 2'b11 : 2'b00;
  assign dir_n[1] = (deb_q[3] & ~deb_q[2]) ? 2'b01 : (deb_q[2] & ~deb_q[3]) ? 2'b11 : 2'b00;
  // A pending tap always wins the tick; the repeat counter only runs while the same direction stays held.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_d[a] = st_q[a];
      dir_d[a] = dir_q[a];
      pend_d[a] = pend_q[a];
      cnt_d[a] = cnt_q[a];
      mv[a] = 1'b0;
      if (frame_tick && pend_q[a]) begin
        mv[a] = 1'b1;
        pend_d[a] = 1'b0;
        cnt_d[a] = RW'(REPEAT_DELAY);
      end else if (frame_tick && st_q[a] != IDLE && dir_n[a] == dir_q[a]) begin
        if (cnt_q[a] == RW'(1)) begin
          mv[a] = 1'b1;
          cnt_d[a] = RW'(REPEAT_RATE);
          st_d[a] = REPEAT;
        end else begin
          cnt_d[a] = cnt_q[a] - RW'(1);
        end
      end
      if (dir_n[a] == 2'b00) begin
        st_d[a] = IDLE;
      end else if (st_q[a] == IDLE || dir_n[a] != dir_q[a]) begin
        dir_d[a] = dir_n[a];
        pend_d[a] = 1'b1;
        st_d[a] = DELAY;
      end
    end
  end
  // 11-bit arithmetic so a step below zero is detected instead of wrapping.
  function automatic logic [9:0] step_pos(input logic [9:0] p, input logic [1:0] d, input logic [10:0] lim);
    logic [10:0] e;
    e = {1'b0, p};
    if (d == 2'b11) e = (e < 11'(STEP)) ? 11'd0 : e - 11'(STEP);
    else if (d == 2'b01) e = (e + 11'(STEP) > lim) ? lim : e + 11'(STEP);
    return e[9:0];
  endfunction
  assign sx_d = mv[0] ? step_pos(sx_q, dir_q[0], MAX_X) : sx_q;
  assign sy_d = mv[1] ? step_pos(sy_q, dir_q[1], MAX_Y) : sy_q;
  assign hit_d = video_on
    && ({1'b0, x} >= {1'b0, sx_q}) && ({1'b0, x} < {1'b0, sx_q} + 11'(SPR_W))
    && ({1'b0, y} >= {1'b0, sy_q}) && ({1'b0, y} < {1'b0, sy_q} + 11'(SPR_H));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
      for (int a = 0; a < 2; a++) begin
        st_q[a] <= IDLE;
        dir_q[a] <= 2'b00;
        pend_q[a] <= 1'b0;
        cnt_q[a] <= '0;
      end
      sx_q <= 10'((SCREEN_W - SPR_W) / 2);
      sy_q <= 10'((SCREEN_H - SPR_H) / 2);
      hit_q <= 1'b0;
      pc_q <= 12'h000;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
      for (int a = 0; a < 2; a++) begin
        st_q[a] <= st_d[a];
        dir_q[a] <= dir_d[a];
        pend_q[a] <= pend_d[a];
        cnt_q[a] <= cnt_d[a];
      end
      sx_q <= sx_d;
      sy_q <= sy_d;
      hit_q <= hit_d;
      pc_q <= hit_d ? COLOR : 12'h000;
    end
  end
  assign sprite_x = sx_q;
  assign sprite_y = sy_q;
  assign sprite_hit = hit_q;
  assign pixel_color = pc_q;
endmodule
